// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: one shared sampler debounces all buttons and queues press/release/long events.
// Optional feature macro: LONG_PRESS_EN (per-button hold counters and LONG events).
module btn_event_ctrl #(
  parameter int unsigned CLK_HZ       = 27_000_000,
  parameter int unsigned SAMPLE_US    = 1000,
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned STABLE_N     = 8,
  parameter int unsigned LONG_SAMPLES = 1000,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [7:0]         o_evt_data,
  output logic               o_overflow,
  input  logic               i_clr_ovf
);

  localparam int unsigned SAMPLE_TICKS = CLK_HZ / 1_000_000 * SAMPLE_US;
  localparam int unsigned PW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int unsigned IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  // Elaboration-time parameter sanity checks
  generate
    if (SAMPLE_TICKS <= NUM_BTN + 2) begin : g_bad_ticks
      $error("btn_event_ctrl: SAMPLE_TICKS must exceed NUM_BTN+2");
    end
    if (NUM_BTN == 0 || NUM_BTN > 64) begin : g_bad_nbtn
      $error("btn_event_ctrl: NUM_BTN out of range");
    end
    if (STABLE_N < 2 || STABLE_N > 255) begin : g_bad_stable
      $error("btn_event_ctrl: STABLE_N out of range");
    end
    if (LONG_SAMPLES == 0 || LONG_SAMPLES > 65535) begin : g_bad_long
      $error("btn_event_ctrl: LONG_SAMPLES out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("btn_event_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  logic [NUM_BTN-1:0] sync_q1, sync_q2, snap_q;
  logic [PW-1:0]      presc_q;
  logic               tick_c;
  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic [7:0]         count_q [NUM_BTN];

  logic       step_c, cur_level_c, cur_snap_c, toggle_c, push_c;
  logic [7:0] count_inc_c, push_data_c;

  // Two-flop synchronizer on the raw buttons
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
    end
  end

  assign tick_c = (presc_q == PW'(SAMPLE_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) presc_q <= '0;
    else       presc_q <= tick_c ? '0 : presc_q + PW'(1);
  end

`ifdef LONG_PRESS_EN
  logic [15:0] hold_q [NUM_BTN];
  logic        long_c;
`endif

  // Debounce decision for the button currently being scanned
  always_comb begin
    step_c      = (state_q == ST_SCAN);
    cur_level_c = o_level[idx_q];
    cur_snap_c  = snap_q[idx_q];
    count_inc_c = (count_q[idx_q] == 8'hFF) ? 8'hFF : count_q[idx_q] + 8'd1;
    toggle_c    = step_c && (cur_snap_c != cur_level_c) && (count_inc_c == 8'(STABLE_N));
    push_c      = toggle_c;
    push_data_c = {cur_level_c ? EVT_RELEASE : EVT_PRESS, 6'(idx_q)};
`ifdef LONG_PRESS_EN
    long_c = step_c && !toggle_c && cur_level_c &&
             (hold_q[idx_q] != 16'(LONG_SAMPLES)) &&
             ((hold_q[idx_q] + 16'd1) == 16'(LONG_SAMPLES));
    if (long_c) begin
      push_c      = 1'b1;
      push_data_c = {2'b11, 6'(idx_q)};
    end
`endif
  end

  // Scan FSM: snapshot on tick, then step one button per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      o_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) count_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_c) begin
            snap_q  <= sync_q2;
            idx_q   <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_snap_c != cur_level_c) count_q[idx_q] <= toggle_c ? 8'd0 : count_inc_c;
          else                           count_q[idx_q] <= 8'd0;
          if (toggle_c) o_level[idx_q] <= ~cur_level_c;
          if (idx_q == IW'(NUM_BTN - 1)) state_q <= ST_IDLE;
          else                           idx_q   <= idx_q + IW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  // Hold counter restarts on any level change and while released
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
    end else if (step_c) begin
      if (toggle_c || !cur_level_c)                  hold_q[idx_q] <= '0;
      else if (hold_q[idx_q] != 16'(LONG_SAMPLES))   hold_q[idx_q] <= hold_q[idx_q] + 16'd1;
    end
  end
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fcount_q, fcount_next_c;
  logic          full_c, pop_c, wr_c, drop_c;

  // Show-ahead FIFO; a full FIFO still accepts a push when popping in the same cycle
  always_comb begin
    full_c        = (fcount_q == CW'(FIFO_DEPTH));
    pop_c         = o_evt_valid && i_evt_ready;
    wr_c          = push_c && (!full_c || pop_c);
    drop_c        = push_c && full_c && !pop_c;
    fcount_next_c = fcount_q;
    if (wr_c && !pop_c)      fcount_next_c = fcount_q + CW'(1);
    else if (pop_c && !wr_c) fcount_next_c = fcount_q - CW'(1);
  end

  assign o_evt_data = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcount_q    <= '0;
      o_evt_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= push_data_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      fcount_q    <= fcount_next_c;
      o_evt_valid <= (fcount_next_c != '0);
      if (drop_c)         o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: randomized/directed bench with a tick-level reference model and an event scoreboard.
module tb_btn_event_ctrl;

  localparam int NB     = 4;
  localparam int TICKS  = 10;
  localparam int STABLE = 4;
  localparam int LONG   = 20;
  localparam int DEPTH  = 4;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic          evt_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [NB-1:0] o_level;
  logic          o_evt_valid;
  logic [7:0]    o_evt_data;
  logic          o_overflow;

  btn_event_ctrl #(
    .CLK_HZ(1_000_000), .SAMPLE_US(10), .NUM_BTN(NB), .STABLE_N(STABLE),
    .LONG_SAMPLES(LONG), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_level(o_level),
    .o_evt_valid(o_evt_valid), .i_evt_ready(evt_ready), .o_evt_data(o_evt_data),
    .o_overflow(o_overflow), .i_clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model state (tick-level view of the specification)
  typedef struct { int unsigned t; logic [7:0] data; } pend_t;
  pend_t         pend_q[$];
  logic [7:0]    exp_q[$];
  int unsigned   gcyc = 0;
  int            phase = 0;
  int            occ = 0;
  logic [NB-1:0] s1 = '0, s2 = '0, lvl_log = '0, mdl_level = '0;
  logic          mdl_ovf = 1'b0;
  int            run [NB];
  int            hold [NB];

  initial begin
    for (int k = 0; k < NB; k++) begin run[k] = 0; hold[k] = 0; end
    forever begin
      int unsigned now;
      bit pop, push, drop;
      logic [7:0] pdata;
      @(posedge clk);
      now = gcyc;
      gcyc++;
      if (rst) begin
        pend_q.delete(); exp_q.delete();
        occ = 0; mdl_level = '0; mdl_ovf = 1'b0; lvl_log = '0;
        s1 = '0; s2 = '0; phase = 0;
        for (int k = 0; k < NB; k++) begin run[k] = 0; hold[k] = 0; end
      end else begin
        pop = (occ > 0) && evt_ready;
        push = 1'b0; drop = 1'b0; pdata = '0;
        if (pend_q.size() > 0 && pend_q[0].t == now) begin
          pend_t p;
          p = pend_q.pop_front();
          push = 1'b1; pdata = p.data;
        end
        if (push) begin
          if (occ < DEPTH || pop) begin exp_q.push_back(pdata); occ++; end
          else drop = 1'b1;
          if (pdata[7:6] == 2'b01)      mdl_level[pdata[1:0]] = 1'b1;
          else if (pdata[7:6] == 2'b10) mdl_level[pdata[1:0]] = 1'b0;
        end
        if (pop) occ--;
        if (drop) mdl_ovf = 1'b1;
        else if (clr_ovf) mdl_ovf = 1'b0;
        if (phase == TICKS - 1) begin
          phase = 0;
          for (int k = 0; k < NB; k++) begin
            pend_t p;
            bit ev;
            ev = 1'b0; p.data = '0;
            if (s2[k] != lvl_log[k]) begin
              run[k]++;
              if (run[k] == STABLE) begin
                run[k] = 0; hold[k] = 0; lvl_log[k] = ~lvl_log[k]; ev = 1'b1;
                p.data = {lvl_log[k] ? 2'b01 : 2'b10, 6'(k)};
              end
            end else run[k] = 0;
            if (!ev && LONG_EN) begin
              if (lvl_log[k]) begin
                if (hold[k] < LONG) begin
                  hold[k]++;
                  if (hold[k] == LONG) begin ev = 1'b1; p.data = {2'b11, 6'(k)}; end
                end
              end else hold[k] = 0;
            end
            if (ev) begin p.t = now + 1 + k; pend_q.push_back(p); end
          end
        end else phase++;
        s2 = s1; s1 = btn;
      end
    end
  end

  // Monitor: every accepted DUT event is popped from the scoreboard and compared
  initial forever begin
    @(negedge clk);
    if (!rst && o_evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL evt_unexpected got %02h expected none", o_evt_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("evt_data", 32'(o_evt_data), 32'(e));
      end
    end
  end

  // Per-cycle state comparison against the model
  initial forever begin
    @(negedge clk);
    chk("level", 32'(o_level), 32'(mdl_level));
    chk("overflow", 32'(o_overflow), 32'(mdl_ovf));
    chk("evt_valid", 32'(o_evt_valid), 32'(occ > 0));
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int mode;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_level", 32'(o_level), 32'h0);
    chk("rst_valid", 32'(o_evt_valid), 32'h0);
    chk("rst_data", 32'(o_evt_data), 32'h0);
    chk("rst_ovf", 32'(o_overflow), 32'h0);

    // Clean press on btn0
    evt_ready = 1'b1;
    step(1); btn = 4'b0001; step(100);
    chk("press_level0", 32'(o_level[0]), 32'h1);

    // Bounce on btn1 must be rejected
    for (int i = 0; i < 20; i++) begin btn[1] = ~btn[1]; step(15); end
    chk("bounce_level1", 32'(o_level[1]), 32'h0);
    btn[1] = 1'b0; step(60);

    // Press then release on btn2
    btn[2] = 1'b1; step(100);
    btn[2] = 1'b0; step(100);

    // Long hold on btn1
    btn[1] = 1'b1; step(460);
    btn[1] = 1'b0; step(80);

    // Overflow: five events with the consumer stalled
    evt_ready = 1'b0;
    btn = 4'b1110; step(80);
    btn = 4'b1111; step(80);
    chk("ovf_set", 32'(o_overflow), 32'h1);
    evt_ready = 1'b1; step(20);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(o_overflow), 32'h0);
    step(1);
    btn = 4'b0001; step(100);

    // Reset with queued events
    evt_ready = 1'b0;
    btn = 4'b1111; step(80);
    chk("queued_valid", 32'(o_evt_valid), 32'h1);
    rst = 1'b1; btn = 4'b0001; step(1); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_evt_valid), 32'h0);
    chk("mid_rst_level", 32'(o_level), 32'h0);
    step(1);
    evt_ready = 1'b1; step(100);
    chk("repress_level0", 32'(o_level[0]), 32'h1);

    // Randomized buttons, consumer stalls and overflow clears
    mode = 2;
    for (int c = 0; c < 3000; c++) begin
      int b;
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 49) == 0) begin b = $urandom_range(0, NB - 1); btn[b] = ~btn[b]; end
      evt_ready = (mode == 2) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
      clr_ovf = ($urandom_range(0, 63) == 0);
      step(1);
    end
    clr_ovf = 1'b0;
    evt_ready = 1'b1;
    step(400);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
